// File: rtl/gtp_prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair: tap table,
// FSM encoding, statistics counter widths and a popcount helper.
package gtp_prbs_pkg;

  localparam int ERR_CNT_W  = 32;
  localparam int WORD_CNT_W = 48;
  localparam int LOSS_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  // Second feedback tap for x^ORDER + x^TAP + 1; unknown orders fall back to PRBS-31.
  function automatic int prbs_tap(input int order);
    case (order)
      7:       return 6;
      15:      return 14;
      23:      return 18;
      default: return 28;
    endcase
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) if (v[i]) n++;
    return n;
  endfunction

endpackage

// File: rtl/prbs_predict.sv
// Self-synchronising predictor: compares each received bit against the XOR of
// the bits ORDER and TAP earlier in serial order, using in-word bits as they arrive.
module prbs_predict
  import gtp_prbs_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PRBS_ORDER = 31
) (
  input  logic [PRBS_ORDER-1:0] history,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic [DATA_WIDTH-1:0] mismatch,
  output logic [PRBS_ORDER-1:0] next_history
);
  localparam int TAP = prbs_tap(PRBS_ORDER);

  // Higher index is earlier in time: chain[DATA_WIDTH] is the newest history bit.
  logic [PRBS_ORDER+DATA_WIDTH-1:0] chain;
  assign chain        = {history, rx_data};
  assign next_history = chain[PRBS_ORDER-1:0];

  always_comb begin
    mismatch = '0;
    for (int p = 0; p < DATA_WIDTH; p++)
      mismatch[p] = chain[p] ^ chain[p+PRBS_ORDER] ^ chain[p+TAP];
    // An all-zero line satisfies the recurrence trivially; flag it as stuck-at-0.
    if (history == '0 && rx_data == '0) mismatch = '1;
  end

endmodule

// File: rtl/prbs_word_checker.sv
// Word-parallel PRBS checker: stage 1 registers the per-word mismatch result,
// stage 2 runs the PRIME/HUNT/LOCKED machine and the statistics counters.
module prbs_word_checker
  import gtp_prbs_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int PRBS_ORDER    = 31,
  parameter int LOCK_WORDS    = 64,
  parameter int UNLOCK_ERRORS = 8,
  parameter int UNLOCK_WINDOW = 256
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              rx_valid,
  input  logic [DATA_WIDTH-1:0]             rx_data,
  input  logic                              clear_counters,
  output logic                              locked,
  output logic                              error_word,
  output logic [$clog2(DATA_WIDTH+1)-1:0]   error_bits,
  output logic [ERR_CNT_W-1:0]              error_count,
  output logic [WORD_CNT_W-1:0]             word_count,
  output logic [LOSS_CNT_W-1:0]             lock_loss_count
);
  localparam int EB_W        = $clog2(DATA_WIDTH+1);
  localparam int PRIME_WORDS = (PRBS_ORDER + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int PC_W        = $clog2(PRIME_WORDS+1);
  localparam int RUN_W       = $clog2(LOCK_WORDS+1);
  localparam int WIN_W       = $clog2(UNLOCK_WINDOW+1);
  localparam int UE_W        = $clog2(UNLOCK_ERRORS+1);

  prbs_state_e           state, state_nx;
  logic [PRBS_ORDER-1:0] history, history_nx;
  logic [DATA_WIDTH-1:0] mismatch;
  logic [PC_W-1:0]       prime_cnt;
  logic                  priming, v1, last_prime1;
  logic [RUN_W-1:0]      run_cnt, run_nx;
  logic [WIN_W-1:0]      win_cnt, win_nx;
  logic [UE_W-1:0]       win_err, win_err_nx;
  logic                  cnt_en, lost;
  logic [ERR_CNT_W:0]    ec_sum;

  prbs_predict #(.DATA_WIDTH(DATA_WIDTH), .PRBS_ORDER(PRBS_ORDER)) u_predict (
    .history      (history),
    .rx_data      (rx_data),
    .mismatch     (mismatch),
    .next_history (history_nx)
  );

  assign priming = (prime_cnt != PC_W'(PRIME_WORDS));
  assign locked  = (state == ST_LOCKED);
  assign ec_sum  = {1'b0, error_count} + (ERR_CNT_W+1)'(error_bits);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      history     <= '0;
      prime_cnt   <= '0;
      v1          <= 1'b0;
      last_prime1 <= 1'b0;
      error_word  <= 1'b0;
      error_bits  <= '0;
    end else begin
      v1          <= rx_valid;
      last_prime1 <= rx_valid && prime_cnt == PC_W'(PRIME_WORDS-1);
      error_word  <= 1'b0;
      error_bits  <= '0;
      if (rx_valid) begin
        history <= history_nx;
        if (priming) prime_cnt <= prime_cnt + 1'b1;
        else begin
          error_word <= |mismatch;
          error_bits <= EB_W'(popcount(64'(mismatch)));
        end
      end
    end
  end

  always_comb begin
    state_nx   = state;
    run_nx     = run_cnt;
    win_nx     = win_cnt;
    win_err_nx = win_err;
    cnt_en     = 1'b0;
    lost       = 1'b0;
    case (state)
      ST_PRIME: if (last_prime1) state_nx = ST_HUNT;
      ST_HUNT: if (v1) begin
        if (error_word) run_nx = '0;
        else if (run_cnt == RUN_W'(LOCK_WORDS-1)) begin
          run_nx     = '0;
          win_nx     = '0;
          win_err_nx = '0;
          state_nx   = ST_LOCKED;
        end else run_nx = run_cnt + 1'b1;
      end
      ST_LOCKED: if (v1) begin
        cnt_en = 1'b1;
        // Unlock takes priority over window roll-over on the window's last word.
        if (error_word && win_err == UE_W'(UNLOCK_ERRORS-1)) begin
          lost       = 1'b1;
          state_nx   = ST_HUNT;
          run_nx     = '0;
          win_nx     = '0;
          win_err_nx = '0;
        end else if (win_cnt == WIN_W'(UNLOCK_WINDOW-1)) begin
          win_nx     = '0;
          win_err_nx = '0;
        end else begin
          win_nx     = win_cnt + 1'b1;
          win_err_nx = win_err + UE_W'(error_word);
        end
      end
      default: state_nx = ST_PRIME;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= ST_PRIME;
      run_cnt         <= '0;
      win_cnt         <= '0;
      win_err         <= '0;
      error_count     <= '0;
      word_count      <= '0;
      lock_loss_count <= '0;
    end else begin
      state   <= state_nx;
      run_cnt <= run_nx;
      win_cnt <= win_nx;
      win_err <= win_err_nx;
      if (clear_counters) begin
        error_count     <= '0;
        word_count      <= '0;
        lock_loss_count <= '0;
      end else begin
        if (cnt_en) begin
          error_count <= ec_sum[ERR_CNT_W] ? '1 : ec_sum[ERR_CNT_W-1:0];
          if (word_count != '1) word_count <= word_count + 1'b1;
        end
        if (lost && lock_loss_count != '1) lock_loss_count <= lock_loss_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_word_checker.sv
// Directed bench for prbs_word_checker: stimulus pushes expected per-word
// results into a queue, a negedge monitor pops and compares them.
module tb_prbs_word_checker;

  logic        clock = 1'b0, reset_n = 1'b0, rx_valid = 1'b0, clear_counters = 1'b0;
  logic [15:0] rx_data = '0;
  logic        locked, error_word;
  logic [4:0]  error_bits;
  logic [31:0] error_count;
  logic [47:0] word_count;
  logic [15:0] lock_loss_count;

  prbs_word_checker dut (
    .clock(clock), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .clear_counters(clear_counters), .locked(locked), .error_word(error_word),
    .error_bits(error_bits), .error_count(error_count), .word_count(word_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic ew; logic [4:0] eb; } exp_t;
  exp_t        expq[$];
  exp_t        mon_e;
  int          vectors = 0, miscompares = 0, pulses = 0, mprime = 0;
  logic        vld_d = 1'b0;
  logic [30:0] gen = 31'h1, rhist = '0;
  logic [63:0] ec0;
  int          p0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clock) vld_d <= rx_valid && reset_n;

  always @(negedge clock) begin
    if (vld_d) begin
      if (expq.size() == 0) check("queue_underflow", 64'd1, 64'd0);
      else begin
        mon_e = expq.pop_front();
        check("error_word", 64'(error_word), 64'(mon_e.ew));
        check("error_bits", 64'(error_bits), 64'(mon_e.eb));
        if (error_word) pulses++;
      end
    end else if (reset_n) check("idle_quiet", 64'({error_word, error_bits}), 64'd0);
  end

  // Bit-serial reference: predict each bit from 31 and 28 bits back.
  task automatic model_word(input logic [15:0] d, output exp_t e);
    int   n;
    logic stuck;
    n     = 0;
    stuck = (rhist == '0) && (d == '0);
    for (int i = 15; i >= 0; i--) begin
      if (d[i] != (rhist[30] ^ rhist[27])) n++;
      rhist = {rhist[29:0], d[i]};
    end
    if (stuck) n = 16;
    if (mprime < 2) begin mprime++; n = 0; end
    e.ew = (n != 0);
    e.eb = 5'(n);
  endtask

  task automatic gen_bit(output logic b);
    b   = gen[30] ^ gen[27];
    gen = {gen[29:0], b};
  endtask

  task automatic gen_word(output logic [15:0] w);
    logic b;
    for (int i = 15; i >= 0; i--) begin gen_bit(b); w[i] = b; end
  endtask

  task automatic send(input logic [15:0] d);
    exp_t e;
    model_word(d, e);
    expq.push_back(e);
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_clean();
    logic [15:0] w;
    gen_word(w);
    send(w);
  endtask

  task automatic send_flip3();
    logic [15:0] w;
    gen_word(w);
    w[3] = ~w[3];
    send(w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    @(posedge clock); #1;
    check("rst_flags", 64'({locked, error_word, error_bits}), 64'd0);
    check("rst_error_count", 64'(error_count), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_lock_loss", 64'(lock_loss_count), 64'd0);
    reset_n = 1'b1;
    rhist   = '0;
    mprime  = 0;
    expq.delete();
  endtask

  initial begin
    logic b;
    do_reset();

    // Clean continuous stream: 2 prime words + 64 clean words.
    for (int i = 1; i <= 66; i++) send_clean();
    check("lock_not_yet", 64'(locked), 64'd0);
    send_clean();
    check("lock_after_66", 64'(locked), 64'd1);
    for (int i = 68; i <= 87; i++) begin
      send_clean();
      check("word_count_step", 64'(word_count), 64'(i - 67));
    end
    check("error_count_clean", 64'(error_count), 64'd0);

    // 8 consecutive corrupted words: 1+1+3*6 = 20 bits counted through the unlocking word.
    for (int i = 0; i < 8; i++) begin
      send_flip3();
      check("locked_in_burst", 64'(locked), 64'd1);
    end
    send_clean();
    check("unlock_after_8th", 64'(locked), 64'd0);
    check("lock_loss_one", 64'(lock_loss_count), 64'd1);
    check("burst_error_count", 64'(error_count), 64'd20);
    check("burst_word_count", 64'(word_count), 64'd29);
    // Two echo words still carry errors, then 64 clean words relock.
    for (int i = 0; i < 65; i++) send_clean();
    check("relock_not_yet", 64'(locked), 64'd0);
    send_clean();
    check("relock", 64'(locked), 64'd1);

    // Single line-bit flip while locked: exactly 3 mismatches over 2 words.
    ec0 = 64'(error_count);
    p0  = pulses;
    send_flip3();
    for (int i = 0; i < 4; i++) send_clean();
    idle(2);
    check("flip_error_count", 64'(error_count), ec0 + 64'd3);
    check("flip_pulses", 64'(pulses - p0), 64'd2);
    check("flip_still_locked", 64'(locked), 64'd1);

    // Clear coinciding with an error-count increment wins.
    send_flip3();
    clear_counters = 1'b1;
    send_clean();
    clear_counters = 1'b0;
    check("clear_error_count", 64'(error_count), 64'd0);
    check("clear_word_count", 64'(word_count), 64'd0);
    check("clear_lock_loss", 64'(lock_loss_count), 64'd0);
    for (int i = 0; i < 3; i++) send_clean();
    check("post_clear_echo", 64'(error_count), 64'd2);
    check("post_clear_words", 64'(word_count), 64'd3);
    check("clear_kept_lock", 64'(locked), 64'd1);

    // Run past a window boundary so earlier error words age out.
    for (int i = 0; i < 300; i++) send_clean();
    check("window_kept_lock", 64'(locked), 64'd1);

    // Stuck-at-0 line while locked.
    for (int j = 0; j < 8; j++) begin
      send(16'h0000);
      if (j >= 2) check("zero_bits16", 64'(error_bits), 64'd16);
      check("zero_locked", 64'(locked), 64'd1);
    end
    send(16'h0000);
    check("zero_unlock", 64'(locked), 64'd0);
    check("zero_lock_loss", 64'(lock_loss_count), 64'd1);
    idle(2);

    // Stream shifted by 5 bits, valid toggling every other cycle.
    do_reset();
    for (int i = 0; i < 5; i++) gen_bit(b);
    for (int i = 1; i <= 66; i++) begin
      send_clean();
      if (i == 66) check("toggle_lock_not_yet", 64'(locked), 64'd0);
      idle(1);
    end
    check("toggle_lock", 64'(locked), 64'd1);
    for (int i = 0; i < 10; i++) begin send_clean(); idle(1); end
    check("toggle_word_count", 64'(word_count), 64'd10);
    check("toggle_error_count", 64'(error_count), 64'd0);
    idle(2);

    // Reset while locked drops everything; relock needs prime + 64 again.
    check("locked_before_reset", 64'(locked), 64'd1);
    do_reset();
    for (int i = 1; i <= 66; i++) send_clean();
    check("post_reset_not_yet", 64'(locked), 64'd0);
    send_clean();
    check("post_reset_relock", 64'(locked), 64'd1);
    idle(3);
    check("queue_drained", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
